// File: rtl/adc_sample_ctrl_pkg.sv
// rtl/adc_sample_ctrl_pkg.sv - register map, bit indices and FSM states shared by the ADC sampler
package adc_sample_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  localparam int STAT_OVF_BIT  = 3;
  localparam int STAT_TMO_BIT  = 4;
  localparam int STAT_BUSY_BIT = 5;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_TRIG_BIT  = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_EOC,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/adc_sample_ctrl_fifo.sv
// rtl/adc_sample_ctrl_fifo.sv - power-of-2 sample FIFO; head is read straight from storage flops
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head     = mem[rd_ptr];
  // A pop frees the slot in the same cycle, so a full FIFO still accepts that push
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// rtl/adc_sample_ctrl.sv - periodic ADC conversion sequencer with sample FIFO and 4-word register slave
module adc_sample_ctrl
  import adc_sample_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int START_W    = 2,
  parameter int TIMEOUT    = 1024,
  parameter int PERIOD_RST = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  adc_data,
  input  logic        adc_eoc,
  output logic        adc_start_n,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(START_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic            eoc_meta, eoc_sync;
  logic            ctrl_en, ctrl_irq_en, cont_mode;
  logic [15:0]     period, period_cnt, eff_period;
  logic            ovf_flag, tmo_flag;
  logic [SW-1:0]   start_cnt;
  logic [TW-1:0]   wait_cnt;
  logic            trig_wr, wr_status, abort, tmo_hit, period_due;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf;
  logic [7:0]      fifo_head;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     count_ext;
  logic [2:0]      count_sat;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  assign trig_wr    = write && (address == ADDR_CTRL) && writedata[CTRL_TRIG_BIT];
  assign wr_status  = write && (address == ADDR_STATUS);
  assign fifo_pop   = read && (address == ADDR_DATA);
  assign fifo_push  = (state == CAPTURE);
  assign eff_period = (period == 16'd0) ? 16'd1 : period;
  // period_cnt counts cycles already elapsed since START entry, so +1 includes the current one
  assign period_due = ({1'b0, period_cnt} + 17'd1) >= {1'b0, eff_period};
  assign abort      = cont_mode && !ctrl_en && (state != IDLE);
  assign tmo_hit    = (state == WAIT_EOC) && !eoc_sync && (wait_cnt == TW'(TIMEOUT - 1));

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (adc_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eoc_meta <= 1'b0;
      eoc_sync <= 1'b0;
    end else begin
      eoc_meta <= adc_eoc;
      eoc_sync <= eoc_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      adc_start_n <= 1'b1;
      start_cnt   <= '0;
      wait_cnt    <= '0;
      period_cnt  <= '0;
      cont_mode   <= 1'b0;
    end else begin
      if (period_cnt != 16'hFFFF) period_cnt <= period_cnt + 1'b1;
      if (abort) begin
        state       <= IDLE;
        adc_start_n <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ctrl_en || trig_wr) begin
              state       <= START;
              adc_start_n <= 1'b0;
              start_cnt   <= '0;
              period_cnt  <= '0;
              cont_mode   <= ctrl_en;
            end
          end
          START: begin
            if (start_cnt == SW'(START_W - 1)) begin
              state       <= WAIT_EOC;
              adc_start_n <= 1'b1;
              wait_cnt    <= '0;
            end else begin
              start_cnt <= start_cnt + 1'b1;
            end
          end
          WAIT_EOC: begin
            if (eoc_sync)     state <= CAPTURE;
            else if (tmo_hit) state <= HOLD;
            else              wait_cnt <= wait_cnt + 1'b1;
          end
          CAPTURE: state <= HOLD;
          HOLD: begin
            if (!cont_mode) begin
              state <= IDLE;
            end else if (period_due) begin
              state       <= START;
              adc_start_n <= 1'b0;
              start_cnt   <= '0;
              period_cnt  <= '0;
            end
          end
          default: begin
            state       <= IDLE;
            adc_start_n <= 1'b1;
          end
        endcase
      end
    end
  end

  assign count_ext = 32'(fifo_count);
  assign count_sat = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: begin
        if (!fifo_empty) rd_mux = {23'b0, 1'b1, fifo_head};
      end
      ADDR_STATUS: begin
        rd_mux[2:0]           = count_sat;
        rd_mux[STAT_OVF_BIT]  = ovf_flag;
        rd_mux[STAT_TMO_BIT]  = tmo_flag;
        rd_mux[STAT_BUSY_BIT] = (state != IDLE);
      end
      ADDR_CTRL: begin
        rd_mux[CTRL_EN_BIT]    = ctrl_en;
        rd_mux[CTRL_IRQEN_BIT] = ctrl_irq_en;
      end
      ADDR_PERIOD: rd_mux[15:0] = period;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      period      <= 16'(PERIOD_RST);
      ovf_flag    <= 1'b0;
      tmo_flag    <= 1'b0;
      readdata    <= '0;
    end else begin
      if (write && (address == ADDR_CTRL)) begin
        ctrl_en     <= writedata[CTRL_EN_BIT];
        ctrl_irq_en <= writedata[CTRL_IRQEN_BIT];
      end
      if (write && (address == ADDR_PERIOD)) period <= writedata[15:0];
      if (fifo_ovf)                                    ovf_flag <= 1'b1;
      else if (wr_status && writedata[STAT_OVF_BIT])   ovf_flag <= 1'b0;
      if (tmo_hit)                                     tmo_flag <= 1'b1;
      else if (wr_status && writedata[STAT_TMO_BIT])   tmo_flag <= 1'b0;
      if (read) readdata <= rd_mux;
    end
  end

  assign irq = ctrl_irq_en & (~fifo_empty | ovf_flag | tmo_flag);

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Sequencing controller for an external 8-bit parallel ADC, in the same Avalon-MM peripheral family as the system's PIO input ports. It issues conversion-start pulses at a programmable period and waits for end-of-conversion with a timeout. Captured bytes are buffered in a small FIFO, and the Nios reads data, status and configuration through a 4-word Avalon-MM slave with read latency 1.

## Interface
- FIFO_DEPTH, 4: sample FIFO depth, power of 2, ≥2
- START_W, 2: adc_start_n low width, cycles, ≥1
- TIMEOUT, 1024: maximum cycles waiting for EOC
- PERIOD_RST, 1000: reset value of PERIOD register
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data; reset 0
- adc_data  in  8  ADC parallel output; must be stable while adc_eoc is high
- adc_eoc  in  1  end of conversion, asynchronous, active-high
- adc_start_n  out  1  conversion start, active-low; reset 1
- irq  out  1  level interrupt; reset 0

## Operation
- Register map:
  - 0 DATA (R): returns {23'b0, valid, sample[7:0]} and pops the FIFO. When empty: returns 0 and does not pop.
  - 1 STATUS (R/W1C): [2:0] count (saturates at FIFO_DEPTH), [3] overflow (sticky), [4] timeout (sticky), [5] busy (FSM not IDLE). Writing 1 to bit 3 or bit 4 clears that bit.
  - 2 CTRL (R/W): [0] enable (continuous mode), [1] trigger (write-1 single shot, self-clearing, reads 0), [2] irq_en.
  - 3 PERIOD (R/W): [15:0] cycles between starts. Value 0 is treated as 1.
- Writes to unused bits are ignored. Reads of unused bits return 0.
- irq = irq_en & (FIFO non-empty | overflow | timeout).
- FSM states and transitions:
  - IDLE → START when enable=1 or a trigger write occurs.
  - START: adc_start_n=0 for START_W cycles → WAIT_EOC.
  - WAIT_EOC: exits on synchronized eoc=1 → CAPTURE. After TIMEOUT cycles with no eoc → set timeout, go to HOLD, no push.
  - CAPTURE: latch adc_data and push to the FIFO → HOLD.
  - HOLD: when the period counter ≥ PERIOD → START if enable=1, else IDLE. A single shot always returns to IDLE.
- Period counter: clears on entry to START and saturates at 0xFFFF. If a conversion takes longer than PERIOD, the next START follows HOLD immediately, one cycle later.
- Clearing enable while busy aborts to IDLE on the next cycle: adc_start_n=1, no push, FIFO contents kept.
- A trigger write while busy is ignored.
- Writing PERIOD takes effect at the next HOLD comparison.
- FIFO rules:
  - Push while full with no pop: drop the new sample and set overflow.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the pop returns valid=0 and the push lands.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: FIFO empty, all registers set to reset values (PERIOD=PERIOD_RST, CTRL=0, flags 0), FSM in IDLE.

## Timing
- Read latency 1: readdata is updated on the clk edge after read=1. The pop takes effect on the same edge. readdata holds its value otherwise.
- Write takes effect on the clk edge where write=1. A simultaneous read and write to the same address returns the pre-write value.
- adc_eoc passes through a 2-flop synchronizer, so EOC-to-CAPTURE is 3 cycles.
- adc_data is sampled in CAPTURE.
- Start-to-start interval equals max(PERIOD, START_W + eoc latency + 4) cycles.

## Structure
- Shared package holds:
  - register address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_PERIOD=3)
  - STATUS/CTRL bit-index constants
  - FSM state enum {IDLE, START, WAIT_EOC, CAPTURE, HOLD}
- One sub-module: sample_fifo (parameterised depth/width, push/pop/full/empty/count, registered output). The FSM and register file live in the top module.

## Test plan
- PERIOD=20, enable=1, ADC model with 5-cycle EOC returning 0x11, 0x22, 0x33 → adc_start_n low 2 cycles every 20 cycles; three DATA reads return 0x111, 0x122, 0x133; a fourth read returns 0.
- trigger with enable=0 → exactly one START pulse, one sample pushed, busy returns to 0, FSM in IDLE.
- Fill 4 samples without reads, then a 5th conversion → STATUS=0x0C (count 4, overflow). W1C of 0x08 → STATUS=0x04. The oldest sample is still first out.
- Pop on the cycle of a push while full → count stays 4, overflow stays 0.
- ADC model never raises EOC → after 1024 cycles timeout=1, no push; with irq_en=1, irq goes high.
- reset_n asserted during WAIT_EOC with 2 samples queued → adc_start_n=1, readdata=0, irq=0, count=0, PERIOD reads 1000.
